// File: rtl/text_vga_gen.sv
// Text-mode VGA adapter: raster counters, one-cell-ahead char/attr/glyph fetch,
// cursor and attribute blink, 16-entry palette onto registered RGB and sync pins.
module text_vga_gen #(
  parameter int          HZV          = 720,
  parameter int          HZF          = 40,
  parameter int          HZS          = 76,
  parameter int          HZB          = 116,
  parameter int          VTV          = 900,
  parameter int          VTF          = 1,
  parameter int          VTS          = 3,
  parameter int          VTB          = 28,
  parameter int          COLS         = 80,
  parameter int          ROWS         = 25,
  parameter int          FONT_H       = 16,
  parameter int          SCALE        = 2,
  parameter int          X_OFF        = 40,
  parameter int          Y_OFF        = 50,
  parameter logic [11:0] BORDER       = 12'h111,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HS,
  output logic        VS,
  output logic        frame,
  input  logic [10:0] cursor,
  input  logic        cursor_en,
  input  logic [3:0]  cursor_start,
  input  logic [3:0]  cursor_end,
  input  logic        blink_en,
  input  logic [7:0]  char_data,
  input  logic [7:0]  font_data,
  output logic [11:0] char_address,
  output logic [11:0] font_address
);
  localparam int LINE = HZB + HZV + HZF + HZS;
  localparam int FRM  = VTB + VTV + VTF + VTS;
  localparam int XW   = $clog2(LINE + 1);
  localparam int YW   = $clog2(FRM + 1);
  localparam int CW   = 8 * SCALE;
  localparam int CWB  = (SCALE == 2) ? 4 : 3;
  localparam int SB   = (SCALE == 2) ? 1 : 0;
  localparam int GB   = (FONT_H == 16) ? 4 : 3;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(LINE - 1);
  localparam logic [XW-1:0] X_VIS0 = XW'(HZB);
  localparam logic [XW-1:0] X_VIS1 = XW'(HZB + HZV);
  localparam logic [XW-1:0] X_HS   = XW'(HZB + HZV + HZF);
  localparam logic [XW-1:0] X_WIN0 = XW'(HZB + X_OFF);
  localparam logic [XW-1:0] X_WIN1 = XW'(HZB + X_OFF + COLS * CW);
  localparam logic [XW-1:0] X_FET0 = XW'(HZB + X_OFF - CW);
  localparam logic [XW-1:0] X_FET1 = XW'(HZB + X_OFF + (COLS - 1) * CW);
  localparam logic [XW-1:0] X_PMSK = XW'(CW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRM - 1);
  localparam logic [YW-1:0] Y_VIS0 = YW'(VTB);
  localparam logic [YW-1:0] Y_VIS1 = YW'(VTB + VTV);
  localparam logic [YW-1:0] Y_VS   = YW'(VTB + VTV + VTF);
  localparam logic [YW-1:0] Y_WIN0 = YW'(VTB + Y_OFF);
  localparam logic [YW-1:0] Y_WIN1 = YW'(VTB + Y_OFF + ROWS * FONT_H * SCALE);
  localparam logic [YW-1:0] Y_GMSK = YW'(FONT_H - 1);
  localparam logic [3:0]    P_LAST = 4'(CW - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [XW-1:0] x_q, x_d, fx_s;
  logic [YW-1:0] y_q, y_d, wy_s, srow_s;
  logic [11:0]   rgb_q, rgb_d, ca_q, ca_d, fa_q, fa_d;
  logic          hs_q, hs_d, vs_q, vs_d, frame_q, frame_d, phase_q, phase_d;
  logic [7:0]    gshadow_q, gshadow_d, ashadow_q, ashadow_d, shift_q, shift_d, attr_q, attr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    glyph_s, p_s, fg_s, bg_s;
  logic [2:0]    pb_s;
  logic [10:0]   cell_base_s, fc_s, cell_s;
  logic          vis_s, rowwin_s, win_s, fetch_s, frame_s, pix_s, cur_s;

  function automatic logic [11:0] pal(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'h000;
      4'd1:    return 12'h005;
      4'd2:    return 12'h070;
      4'd3:    return 12'h075;
      4'd4:    return 12'h700;
      4'd5:    return 12'h705;
      4'd6:    return 12'h770;
      4'd7:    return 12'hAAA;
      4'd8:    return 12'h555;
      4'd9:    return 12'h00F;
      4'd10:   return 12'h0F0;
      4'd11:   return 12'h0FF;
      4'd12:   return 12'hF00;
      4'd13:   return 12'hF0F;
      4'd14:   return 12'hFF0;
      4'd15:   return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // Geometry: fetch column fc runs one cell ahead, so the displayed cell is fc-1.
  always_comb begin
    fx_s        = x_q - X_FET0;
    wy_s        = y_q - Y_WIN0;
    srow_s      = wy_s >> SB;
    glyph_s     = 4'(srow_s & Y_GMSK);
    cell_base_s = 11'(srow_s >> GB) * 11'(COLS);
    fc_s        = 11'(fx_s >> CWB);
    p_s         = 4'(fx_s & X_PMSK);
    pb_s        = 3'(p_s >> SB);
    cell_s      = cell_base_s + fc_s - 11'd1;
    vis_s       = (x_q >= X_VIS0) && (x_q < X_VIS1) && (y_q >= Y_VIS0) && (y_q < Y_VIS1);
    rowwin_s    = (y_q >= Y_WIN0) && (y_q < Y_WIN1);
    win_s       = rowwin_s && (x_q >= X_WIN0) && (x_q < X_WIN1);
    fetch_s     = rowwin_s && (x_q >= X_FET0) && (x_q < X_FET1);
    frame_s     = (y_q == Y_VIS1) && (x_q == {XW{1'b0}});
    pix_s       = shift_q[3'd7 - pb_s];
    cur_s       = cursor_en && phase_q && (cell_s == cursor) &&
                  (cursor_start <= glyph_s) && (glyph_s <= cursor_end);
  end

  // Next state for counters, fetch pipeline and blink timer.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    ca_d      = ca_q;
    fa_d      = fa_q;
    gshadow_d = gshadow_q;
    ashadow_d = ashadow_q;
    shift_d   = shift_q;
    attr_d    = attr_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    if (x_q == X_LAST) begin
      x_d = {XW{1'b0}};
      if (y_q == Y_LAST) y_d = {YW{1'b0}};
      else               y_d = y_q + YW'(1);
    end else begin
      x_d = x_q + XW'(1);
    end
    if (fetch_s) begin
      case (p_s)
        4'd0: ca_d = {cell_base_s + fc_s, 1'b0};
        4'd2: begin
          fa_d = {char_data, glyph_s};
          ca_d = {cell_base_s + fc_s, 1'b1};
        end
        4'd4: begin
          gshadow_d = font_data;
          ashadow_d = char_data;
        end
        P_LAST: begin
          shift_d = gshadow_q;
          attr_d  = ashadow_q;
        end
        default: ca_d = ca_q;
      endcase
    end else begin
      ca_d = ca_q;
    end
    if (frame_s) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d  = {BW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Colour and sync selection for the pixel at the current counter position.
  always_comb begin
    if (blink_en) bg_s = {1'b0, attr_q[6:4]};
    else          bg_s = attr_q[7:4];
    if (blink_en && attr_q[7] && phase_q) fg_s = bg_s;
    else                                  fg_s = attr_q[3:0];
    if (!vis_s)                rgb_d = 12'h000;
    else if (!win_s)           rgb_d = BORDER;
    else if (pix_s || cur_s)   rgb_d = pal(fg_s);
    else                       rgb_d = pal(bg_s);
    hs_d    = (x_q < X_HS);
    vs_d    = (y_q >= Y_VS);
    frame_d = frame_s;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= {XW{1'b0}};
      y_q       <= {YW{1'b0}};
      rgb_q     <= 12'h000;
      hs_q      <= 1'b1;
      vs_q      <= 1'b0;
      frame_q   <= 1'b0;
      ca_q      <= 12'h000;
      fa_q      <= 12'h000;
      gshadow_q <= 8'h00;
      ashadow_q <= 8'h00;
      shift_q   <= 8'h00;
      attr_q    <= 8'h00;
      bcnt_q    <= {BW{1'b0}};
      phase_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      frame_q   <= frame_d;
      ca_q      <= ca_d;
      fa_q      <= fa_d;
      gshadow_q <= gshadow_d;
      ashadow_q <= ashadow_d;
      shift_q   <= shift_d;
      attr_q    <= attr_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
    end
  end

  assign R            = rgb_q[11:8];
  assign G            = rgb_q[7:4];
  assign B            = rgb_q[3:0];
  assign HS           = hs_q;
  assign VS           = vs_q;
  assign frame        = frame_q;
  assign char_address = ca_q;
  assign font_address = fa_q;
endmodule

// File: tb/tb_text_vga_gen.sv
// Directed bench: a shrunken raster (100-clock lines, 46-line frames, 4x2 cells)
// for fetch/colour/cursor/blink, plus a default-parameter instance for HS timing.
module tb_text_vga_gen;
  localparam int LINE = 100;
  localparam int FCLK = 4600;

  logic        clk, rst_n;
  logic [3:0]  r, g, b, r2, g2, b2;
  logic        hs, vs, frm, hs2, vs2, frm2;
  logic [10:0] cursor;
  logic        cursor_en, blink_en;
  logic [3:0]  cursor_start, cursor_end;
  logic [7:0]  char_data, font_data;
  logic [11:0] char_address, font_address, ca2, fa2;
  logic [7:0]  cmem [0:4095];
  logic [7:0]  fmem [0:4095];
  int          ntests, nfail, t;

  text_vga_gen #(
    .HZV(80), .HZF(4), .HZS(6), .HZB(10), .VTV(40), .VTF(1), .VTS(2), .VTB(3),
    .COLS(4), .ROWS(2), .FONT_H(8), .SCALE(2), .X_OFF(8), .Y_OFF(4),
    .BORDER(12'h111), .BLINK_FRAMES(2)
  ) u_dut (
    .clock(clk), .reset_n(rst_n), .R(r), .G(g), .B(b), .HS(hs), .VS(vs), .frame(frm),
    .cursor(cursor), .cursor_en(cursor_en), .cursor_start(cursor_start),
    .cursor_end(cursor_end), .blink_en(blink_en), .char_data(char_data),
    .font_data(font_data), .char_address(char_address), .font_address(font_address)
  );

  text_vga_gen u_def (
    .clock(clk), .reset_n(rst_n), .R(r2), .G(g2), .B(b2), .HS(hs2), .VS(vs2), .frame(frm2),
    .cursor(cursor), .cursor_en(cursor_en), .cursor_start(cursor_start),
    .cursor_end(cursor_end), .blink_en(blink_en), .char_data(8'h00),
    .font_data(8'h00), .char_address(ca2), .font_address(fa2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous video RAMs with one clock of read latency.
  always_ff @(posedge clk) begin
    char_data <= cmem[char_address];
    font_data <= fmem[font_address];
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic go_t(input int tgt);
    if (tgt > t) begin
      repeat (tgt - t) @(posedge clk);
      #1;
      t = tgt;
    end else if (tgt < t) begin
      nfail++;
      $error("FAIL seq: target %0d already passed at %0d", tgt, t);
    end else begin
      t = tgt;
    end
  endtask

  // Sample the output that reflects counter position (y, x) of frame f.
  task automatic go(input int f, input int y, input int x);
    go_t(f * FCLK + y * LINE + x + 1);
  endtask

  initial begin
    ntests = 0; nfail = 0; t = 0;
    rst_n = 1'b0; cursor = 11'd5; cursor_en = 1'b1;
    cursor_start = 4'd6; cursor_end = 4'd7; blink_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      cmem[i] = 8'h00;
      fmem[i] = 8'h00;
    end
    for (int c = 0; c < 8; c++) begin
      cmem[2 * c]     = 8'h41;
      cmem[2 * c + 1] = 8'h1E;
    end
    cmem[2] = 8'h42; cmem[3] = 8'h07; cmem[5] = 8'h9E;
    for (int rr = 0; rr < 8; rr++) begin
      fmem[12'h410 + rr] = 8'h81;
      fmem[12'h420 + rr] = 8'hF0;
    end

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (1530) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", {r, g, b}, 12'h000);
    check("rst_hs", 12'(hs), 12'h001);
    check("rst_vs", 12'(vs), 12'h000);
    check("rst_frame", 12'(frm), 12'h000);
    check("rst_caddr", char_address, 12'h000);
    check("rst_faddr", font_address, 12'h000);
    check("rst_def_rgb", {r2, g2, b2}, 12'h000);
    check("rst_def_sync", {9'd0, hs2, vs2, frm2}, 12'h004);
    check("rst_def_addr", ca2 | fa2, 12'h000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    t = 0;
    check("rel_hs", 12'(hs), 12'h001);
    go(0, 0, 0);   check("start_rgb", {r, g, b}, 12'h000);
    check("start_hs", 12'(hs), 12'h001);

    // First text line: fetch addresses and the pixel row of cells 0..3.
    go(0, 7, 1);   check("ca_idle", char_address, 12'h000);
    go(0, 7, 4);   check("ca_attr0", char_address, 12'h001);
    check("fa_A0", font_address, 12'h410);
    go(0, 7, 9);   check("porch_px", {r, g, b}, 12'h000);
    go(0, 7, 10);  check("vis_border", {r, g, b}, 12'h111);
    go(0, 7, 17);  check("win_m1", {r, g, b}, 12'h111);
    go(0, 7, 18);  check("c0_p0", {r, g, b}, 12'hFF0);
    check("ca_char1", char_address, 12'h002);
    go(0, 7, 19);  check("c0_p1", {r, g, b}, 12'hFF0);
    go(0, 7, 20);  check("c0_p2", {r, g, b}, 12'h005);
    check("fa_B0", font_address, 12'h420);
    check("ca_attr1", char_address, 12'h003);
    go(0, 7, 31);  check("c0_p13", {r, g, b}, 12'h005);
    go(0, 7, 32);  check("c0_p14", {r, g, b}, 12'hFF0);
    go(0, 7, 33);  check("c0_p15", {r, g, b}, 12'hFF0);
    go(0, 7, 34);  check("c1_p0", {r, g, b}, 12'hAAA);
    go(0, 7, 41);  check("c1_p7", {r, g, b}, 12'hAAA);
    go(0, 7, 42);  check("c1_p8", {r, g, b}, 12'h000);
    go(0, 7, 50);  check("c2_fg_ph0", {r, g, b}, 12'hFF0);
    go(0, 7, 52);  check("c2_bg_blink", {r, g, b}, 12'h005);
    go(0, 7, 81);  check("c3_last", {r, g, b}, 12'hFF0);
    go(0, 7, 82);  check("win_end", {r, g, b}, 12'h111);
    go(0, 7, 90);  check("fporch_px", {r, g, b}, 12'h000);
    go(0, 7, 93);  check("hs_before", 12'(hs), 12'h001);
    go(0, 7, 94);  check("hs_fall", 12'(hs), 12'h000);

    // Default geometry: HS low from X=876 for 76 clocks, 952-clock line.
    go_t(876);     check("def_hs_hi", 12'(hs2), 12'h001);
    go_t(877);     check("def_hs_lo", 12'(hs2), 12'h000);
    go_t(952);     check("def_hs_end", 12'(hs2), 12'h000);
    go_t(953);     check("def_hs_rise", 12'(hs2), 12'h001);
    go_t(1828);    check("def_hs_l1hi", 12'(hs2), 12'h001);
    go_t(1829);    check("def_hs_l1lo", 12'(hs2), 12'h000);

    go(0, 35, 4);  check("fa_row6", font_address, 12'h416);
    check("ca_attr4", char_address, 12'h009);
    go(0, 35, 18); check("c4_p0", {r, g, b}, 12'hFF0);
    go(0, 35, 36); check("cur_ph0", {r, g, b}, 12'h005);
    go(0, 40, 50); check("ca_hold", char_address, 12'h00F);
    check("fa_hold", font_address, 12'h417);
    go(0, 42, 99); check("frame_pre", 12'(frm), 12'h000);
    go(0, 43, 0);  check("frame_pulse", 12'(frm), 12'h001);
    go(0, 43, 1);  check("frame_post", 12'(frm), 12'h000);
    go(0, 43, 50); check("vs_fp", 12'(vs), 12'h000);
    go(0, 44, 0);  check("vs_on", 12'(vs), 12'h001);
    go(0, 45, 99); check("vs_last", {10'd0, vs, hs}, 12'h002);
    go(1, 0, 0);   check("wrap_sync", {10'd0, vs, hs}, 12'h001);

    blink_en = 1'b0;
    go(1, 7, 50);  check("nb_fg", {r, g, b}, 12'hFF0);
    go(1, 7, 52);  check("nb_bg9", {r, g, b}, 12'h00F);
    blink_en = 1'b1;

    // Frames 2 and 3 run with blink phase 1.
    go(2, 7, 18);  check("ph1_plain", {r, g, b}, 12'hFF0);
    go(2, 7, 50);  check("ph1_blink", {r, g, b}, 12'h005);
    go(2, 34, 36); check("cur_row5", {r, g, b}, 12'h005);
    go(2, 35, 20); check("cur_cell4", {r, g, b}, 12'h005);
    go(2, 35, 36); check("cur_on6", {r, g, b}, 12'hFF0);
    go(2, 35, 52); check("cur_cell6", {r, g, b}, 12'h005);
    go(2, 38, 36); check("cur_on7", {r, g, b}, 12'hFF0);
    go(2, 39, 36); check("bottom_border", {r, g, b}, 12'h111);
    cursor_start = 4'd7; cursor_end = 4'd6;
    go(3, 7, 50);  check("ph1_blink_f3", {r, g, b}, 12'h005);
    go(3, 35, 36); check("cur_inverted", {r, g, b}, 12'h005);
    cursor = 11'd13; cursor_start = 4'd6; cursor_end = 4'd7;
    go(3, 36, 36); check("cur_oob", {r, g, b}, 12'h005);
    cursor = 11'd5;
    go(3, 37, 36); check("cur_back", {r, g, b}, 12'hFF0);
    go(4, 7, 50);  check("ph0_again", {r, g, b}, 12'hFF0);
    go(4, 35, 36); check("cur_ph0_f4", {r, g, b}, 12'h005);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
